// File: rtl/msg_arbiter.sv
// Purpose: round-robin arbiter sharing one head/data/tail message channel among NREQ requesters.
// Latency: 1 cycle from an eligible head to grant; beats then pass through combinationally (0 cycles).
// Backpressure: out_ready is forwarded to the owner only; everyone else sees req_ready=0 until the owner's tail is taken.
//
// Ports:
//   clock, reset           system clock; synchronous active-high reset
//   req_valid/head/tail    per-requester beat qualifiers (NREQ bits each)
//   req_data               per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   req_ready              beat accepted from requester i this cycle
//   out_valid/head/tail    downstream beat qualifiers (muxed from the owner)
//   out_data, out_ready    downstream payload and acceptance
//   grant                  registered one-hot owner, 0 when idle
//   msg_ip                 message in progress (registered state is not idle)
//   proto_err              one-cycle pulse after a framing violation by the owner
module msg_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_head,
  input  logic [NREQ-1:0]        req_tail,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   out_valid,
  output logic                   out_head,
  output logic                   out_tail,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [NREQ-1:0]        grant,
  output logic                   msg_ip,
  output logic                   proto_err
);

  localparam int PTR_W = (NREQ <= 2) ? 1 : $clog2(NREQ);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HEAD = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  arb_state_t        state, state_nxt;
  logic [NREQ-1:0]   grant_nxt;
  logic [PTR_W-1:0]  last, last_nxt;
  logic              err_nxt;

  logic [PTR_W-1:0]  own_idx;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_vld;
  logic [NREQ-1:0]   eligible;
  logic              live;
  logic              beat;
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Only heads may start a message; a stray data beat from an idle requester
  // simply waits and is never granted.
  assign eligible = req_valid & req_head;

  // Nothing is forwarded in the reset cycle so a dropped message cannot leak
  // a beat downstream.
  assign live   = ~reset & (state != ARB_IDLE);
  assign msg_ip = (state != ARB_IDLE);

  // Grant is one-hot, so the owner index is a plain encoder.
  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) own_idx = PTR_W'(i);
    end
  end

  // Round-robin search starting just after the last completed owner.
  always_comb begin
    int idx;
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!pick_vld && eligible[idx]) begin
        pick_vld = 1'b1;
        pick_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    out_data  = '0;
    req_ready = '0;
    if (live) begin
      out_valid = req_valid[own_idx];
      out_head  = req_head[own_idx];
      out_tail  = req_tail[own_idx];
      out_data  = data_arr[own_idx];
      req_ready = grant & {NREQ{out_ready}};
    end
  end

  assign beat = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    err_nxt   = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          grant_nxt = NREQ'(1) << pick_idx;
          state_nxt = ARB_HEAD;
        end
      end
      ARB_HEAD, ARB_DATA: begin
        if (beat) begin
          // First beat must carry head; later beats must not.
          if (state == ARB_HEAD) err_nxt = ~out_head;
          else                   err_nxt = out_head;
          if (out_tail) begin
            state_nxt = ARB_IDLE;
            grant_nxt = '0;
            last_nxt  = own_idx;
          end else begin
            state_nxt = ARB_DATA;
          end
        end
      end
      default: begin
        state_nxt = ARB_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ARB_IDLE;
      grant     <= '0;
      last      <= PTR_W'(NREQ - 1);
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      last      <= last_nxt;
      proto_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_msg_arbiter.sv
module tb_msg_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_head, req_tail, req_ready;
  logic [NREQ*DW-1:0] req_data;
  logic              out_valid, out_head, out_tail, out_ready;
  logic [DW-1:0]     out_data;
  logic [NREQ-1:0]   grant;
  logic              msg_ip, proto_err;

  msg_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_head(req_head), .req_tail(req_tail),
    .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_head(out_head), .out_tail(out_tail),
    .out_data(out_data), .out_ready(out_ready),
    .grant(grant), .msg_ip(msg_ip), .proto_err(proto_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 = channel free), last finished owner,
  // beats forwarded in the current message, pending error pulse.
  int m_owner = -1;
  int m_last  = NREQ - 1;
  int m_beats = 0;
  bit m_err   = 1'b0;
  logic [NREQ-1:0] m_acc;

  // Values observed in the latest cycle, for scenario-specific checks.
  logic [NREQ-1:0] obs_grant, obs_ready;
  logic            obs_msg_ip, obs_err, obs_valid, obs_head, obs_tail;
  logic [DW-1:0]   obs_data;

  // Random-phase source generators.
  int            g_len [NREQ];
  int            g_pos [NREQ];
  int            g_bad [NREQ];
  int            g_junk[NREQ];
  logic [DW-1:0] g_dat [NREQ];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_beat(input int i, input logic v, input logic h, input logic t,
                          input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_head[i]           = h;
    req_tail[i]           = t;
    req_data[i*DW +: DW]  = d;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_head = '0; req_tail = '0; req_data = '0;
  endtask

  // One clock: compare every DUT output with the model on the falling edge,
  // then advance the model with the inputs held over the rising edge.
  task automatic tick();
    logic [31:0] e_grant, e_ready, e_valid, e_head, e_tail, e_data;
    bit live, found, nerr;
    int idx;
    @(negedge clock);
    live    = !reset && (m_owner >= 0);
    e_grant = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
    e_ready = 0; e_valid = 0; e_head = 0; e_tail = 0; e_data = 0;
    if (live) begin
      e_valid = 32'(req_valid[m_owner]);
      e_head  = 32'(req_head[m_owner]);
      e_tail  = 32'(req_tail[m_owner]);
      e_data  = 32'(req_data[m_owner*DW +: DW]);
      e_ready = out_ready ? (32'd1 << m_owner) : 32'd0;
    end
    obs_grant = grant; obs_ready = req_ready; obs_msg_ip = msg_ip; obs_err = proto_err;
    obs_valid = out_valid; obs_head = out_head; obs_tail = out_tail; obs_data = out_data;
    chk("grant",     32'(grant),     e_grant);
    chk("msg_ip",    32'(msg_ip),    32'(m_owner >= 0));
    chk("proto_err", 32'(proto_err), 32'(m_err));
    chk("req_ready", 32'(req_ready), e_ready);
    chk("out_valid", 32'(out_valid), e_valid);
    chk("out_head",  32'(out_head),  e_head);
    chk("out_tail",  32'(out_tail),  e_tail);
    chk("out_data",  32'(out_data),  e_data);
    m_acc = e_ready[NREQ-1:0] & req_valid;
    if (reset) begin
      m_owner = -1; m_last = NREQ - 1; m_err = 1'b0; m_beats = 0;
    end else begin
      nerr = 1'b0;
      if (m_owner < 0) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_last + k) % NREQ;
          if (!found && req_valid[idx] && req_head[idx]) begin
            found = 1'b1; m_owner = idx; m_beats = 0;
          end
        end
      end else if (e_valid[0] && out_ready) begin
        if ((m_beats == 0) != (e_head[0] == 1'b1)) nerr = 1'b1;
        m_beats++;
        if (e_tail[0]) begin
          m_last = m_owner; m_owner = -1;
        end
      end
      m_err = nerr;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; out_ready = 1'b0; clear_inputs();

    // Reset held for three cycles with idle inputs.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_grant", 32'(obs_grant), 32'd0);
      chk("rst_valid", 32'(obs_valid), 32'd0);
    end
    reset = 1'b0;

    // Four-beat message from requester 1.
    out_ready = 1'b1;
    set_beat(1, 1, 1, 0, 8'h11);
    tick(); chk("arb_latency", 32'(obs_grant), 32'd0);
    tick(); chk("g1_grant", 32'(obs_grant), 32'b0010); chk("g1_d11", 32'(obs_data), 32'h11);
    set_beat(1, 1, 0, 0, 8'h22); tick(); chk("g1_d22", 32'(obs_data), 32'h22);
    set_beat(1, 1, 0, 0, 8'h33); tick(); chk("g1_d33", 32'(obs_data), 32'h33);
    set_beat(1, 1, 0, 1, 8'h44); tick(); chk("g1_d44", 32'(obs_data), 32'h44);
    chk("g1_tail", 32'(obs_tail), 32'd1); chk("g1_ip", 32'(obs_msg_ip), 32'd1);
    set_beat(1, 0, 0, 0, 8'h00); tick();
    chk("g1_idle", 32'(obs_grant), 32'd0); chk("g1_ip_end", 32'(obs_msg_ip), 32'd0);

    // Fairness: 0 and 2 together after reset, 0 re-requests.
    reset = 1'b1; tick(); reset = 1'b0;
    set_beat(0, 1, 1, 1, 8'hA0); set_beat(2, 1, 1, 1, 8'hC2);
    tick(); tick(); chk("rr_first", 32'(obs_grant), 32'b0001);
    set_beat(0, 1, 1, 1, 8'hA1);
    tick(); tick(); chk("rr_second", 32'(obs_grant), 32'b0100);
    set_beat(2, 0, 0, 0, 8'h00); set_beat(3, 1, 1, 1, 8'hD3);
    // last=2: search order is 3,0,1,2.
    tick(); tick(); chk("rr_third", 32'(obs_grant), 32'b1000);
    set_beat(3, 0, 0, 0, 8'h00);
    tick(); tick(); chk("rr_fourth", 32'(obs_grant), 32'b0001);
    clear_inputs(); tick();

    // Stall, valid gap and a blocked competitor; last=0 now.
    set_beat(0, 1, 1, 0, 8'h50);
    tick(); tick(); chk("st_grant", 32'(obs_grant), 32'b0001);
    set_beat(0, 1, 0, 0, 8'h55); set_beat(3, 1, 1, 1, 8'hA5); set_beat(1, 1, 0, 0, 8'h77);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("st_hold", 32'(obs_grant), 32'b0001); chk("st_nordy", 32'(obs_ready), 32'd0);
    end
    out_ready = 1'b1; set_beat(0, 0, 0, 0, 8'h55);
    tick(); chk("st_gap", 32'(obs_valid), 32'd0); chk("st_gap_g", 32'(obs_grant), 32'b0001);
    set_beat(0, 1, 0, 1, 8'h66);
    tick(); chk("st_tail", 32'(obs_data), 32'h66);
    set_beat(0, 0, 0, 0, 8'h00);
    tick(); chk("st_gapcyc", 32'(obs_grant), 32'd0); chk("idle_nonhead", 32'(obs_ready), 32'd0);
    tick(); chk("sb_grant", 32'(obs_grant), 32'b1000);
    chk("sb_flags", 32'({obs_head, obs_tail}), 32'b11); chk("sb_data", 32'(obs_data), 32'hA5);
    set_beat(3, 0, 0, 0, 8'h00);
    tick(); chk("sb_idle", 32'(obs_msg_ip), 32'd0);
    set_beat(1, 0, 0, 0, 8'h00);

    // Nested head inside a message.
    set_beat(0, 1, 1, 0, 8'h01);
    tick(); tick();
    set_beat(0, 1, 1, 0, 8'h02); tick(); chk("pe_before", 32'(obs_err), 32'd0);
    set_beat(0, 0, 0, 0, 8'h00); tick(); chk("pe_pulse", 32'(obs_err), 32'd1);
    tick(); chk("pe_clear", 32'(obs_err), 32'd0);

    // Reset in the middle of the message.
    reset = 1'b1; set_beat(0, 1, 0, 0, 8'h03);
    tick(); chk("mr_nobeat", 32'(obs_valid), 32'd0);
    reset = 1'b0; set_beat(0, 0, 0, 0, 8'h00);
    tick(); chk("mr_grant", 32'(obs_grant), 32'd0); chk("mr_ip", 32'(obs_msg_ip), 32'd0);
    set_beat(0, 1, 1, 0, 8'h04); set_beat(3, 1, 1, 0, 8'h05);
    tick(); tick(); chk("mr_restart", 32'(obs_grant), 32'b0001);
    clear_inputs(); reset = 1'b1; tick(); reset = 1'b0;

    // Randomized traffic with occasional framing errors, junk beats and resets.
    for (int i = 0; i < NREQ; i++) begin g_len[i] = 0; g_junk[i] = 0; g_pos[i] = 0; g_bad[i] = -1; end
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 399) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (g_len[i] == 0 && g_junk[i] == 0) begin
          if ($urandom_range(0, 7) == 0) begin
            g_junk[i] = $urandom_range(1, 3);
            g_dat[i]  = DW'($urandom);
          end else if ($urandom_range(0, 1) == 0) begin
            g_len[i] = $urandom_range(1, 4);
            g_pos[i] = 0;
            g_bad[i] = (g_len[i] >= 3 && $urandom_range(0, 7) == 0) ? 1 : -1;
            g_dat[i] = DW'($urandom);
          end
        end
        if (g_junk[i] > 0)
          set_beat(i, 1, 0, 0, g_dat[i]);
        else if (g_len[i] > 0)
          set_beat(i, ($urandom_range(0, 3) != 0),
                   (g_pos[i] == 0) || (g_pos[i] == g_bad[i]),
                   (g_pos[i] == g_len[i] - 1), g_dat[i]);
        else
          set_beat(i, 0, 0, 0, 8'h00);
      end
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (reset) begin
          g_len[i] = 0; g_junk[i] = 0;
        end else if (g_junk[i] > 0) begin
          g_junk[i]--;
        end else if (g_len[i] > 0 && m_acc[i]) begin
          g_pos[i]++;
          g_dat[i] = DW'($urandom);
          if (g_pos[i] == g_len[i]) g_len[i] = 0;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
